// File: rtl/ika87ad_mcseq_if.sv
// Decoder/datapath-facing bus of the IKA87AD microcode sequencer: sequence control,
// microcode store write port and the registered microword outputs.
interface ika87ad_mcseq_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 18,
  parameter int REP_W  = 3
);
  localparam int SW = DATA_W + REP_W + 1;

  logic              i_TICK;
  logic              i_START;
  logic [ADDR_W-1:0] i_ENTRY;
  logic              i_ABORT;
  logic              i_WR_EN;
  logic [ADDR_W-1:0] i_WR_ADDR;
  logic [SW-1:0]     i_WR_DATA;

  logic [DATA_W-1:0] o_MC_DATA;
  logic              o_MC_VALID;
  logic              o_MC_REPEAT;
  logic              o_BUSY;
  logic [ADDR_W-1:0] o_UPC;
  logic              o_WRAP;

  modport slave (
    input  i_TICK, i_START, i_ENTRY, i_ABORT, i_WR_EN, i_WR_ADDR, i_WR_DATA,
    output o_MC_DATA, o_MC_VALID, o_MC_REPEAT, o_BUSY, o_UPC, o_WRAP
  );

  modport master (
    output i_TICK, i_START, i_ENTRY, i_ABORT, i_WR_EN, i_WR_ADDR, i_WR_DATA,
    input  o_MC_DATA, o_MC_VALID, o_MC_REPEAT, o_BUSY, o_UPC, o_WRAP
  );
endinterface

// File: rtl/ika87ad_mcseq.sv
// Writable-store microcode sequencer: owns the micro-PC, walks words until END,
// re-presents words REPEAT extra times, and drives a registered microword.
module ika87ad_mcseq #(
  parameter int                ADDR_W    = 8,
  parameter int                DATA_W    = 18,
  parameter int                REP_W     = 3,
  parameter logic [DATA_W-1:0] IDLE_WORD = {DATA_W{1'b0}}
) (
  input logic            i_CLK,
  input logic            i_RST_n,
  ika87ad_mcseq_if.slave bus
);
  localparam int                SW      = DATA_W + REP_W + 1;
  localparam int                DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] UPC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] UPC_MAX = {ADDR_W{1'b1}};
  localparam logic [REP_W-1:0]  REP_ONE = {{(REP_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_REP  = 2'd2
  } state_t;

  logic [SW-1:0]     r_mem [DEPTH];

  state_t            r_state,     w_state;
  logic [REP_W-1:0]  r_rep_cnt,   w_rep_cnt;
  logic              r_end,       w_end;
  logic [DATA_W-1:0] r_data_p1,   w_data_p1;
  logic              r_vld_p1,    w_vld_p1;
  logic              r_repeat_p1, w_repeat_p1;
  logic              r_busy,      w_busy;
  logic [ADDR_W-1:0] r_upc,       w_upc;
  logic              r_wrap,      w_wrap;

  logic [ADDR_W-1:0] w_fetch_addr;
  logic [SW-1:0]     w_fetch_word;
  logic              w_f_end;
  logic [REP_W-1:0]  w_f_rep;
  logic [DATA_W-1:0] w_f_pay;

  // Store: no reset so contents survive i_RST_n; writes ignore i_TICK
  always_ff @(posedge i_CLK) begin
    if (bus.i_WR_EN) r_mem[bus.i_WR_ADDR] <= bus.i_WR_DATA;
  end

  // Fetch address is set up a cycle ahead: the entry while idle, uPC+1 while running.
  // The read is asynchronous, so a same-edge write still returns the old word.
  assign w_fetch_addr = (r_state == S_IDLE) ? bus.i_ENTRY : (r_upc + UPC_ONE);
  assign w_fetch_word = r_mem[w_fetch_addr];
  assign w_f_end      = w_fetch_word[SW-1];
  assign w_f_rep      = w_fetch_word[SW-2 -: REP_W];
  assign w_f_pay      = w_fetch_word[DATA_W-1:0];

  always_comb begin
    w_state     = r_state;
    w_rep_cnt   = r_rep_cnt;
    w_end       = r_end;
    w_data_p1   = r_data_p1;
    w_vld_p1    = r_vld_p1;
    w_repeat_p1 = r_repeat_p1;
    w_busy      = r_busy;
    w_upc       = r_upc;
    w_wrap      = r_wrap;

    if (bus.i_TICK) begin
      if (bus.i_ABORT) begin
        w_state     = S_IDLE;
        w_rep_cnt   = '0;
        w_data_p1   = IDLE_WORD;
        w_vld_p1    = 1'b0;
        w_repeat_p1 = 1'b0;
        w_busy      = 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (bus.i_START) begin
              w_state     = (w_f_rep != '0) ? S_REP : S_RUN;
              w_rep_cnt   = w_f_rep;
              w_end       = w_f_end;
              w_data_p1   = w_f_pay;
              w_vld_p1    = 1'b1;
              w_repeat_p1 = 1'b0;
              w_busy      = 1'b1;
              w_upc       = w_fetch_addr;
              w_wrap      = 1'b0;
            end
          end
          S_REP: begin
            w_repeat_p1 = 1'b1;
            w_rep_cnt   = r_rep_cnt - REP_ONE;
            if (r_rep_cnt == REP_ONE) w_state = S_RUN;
          end
          S_RUN: begin
            if (r_end) begin
              w_state     = S_IDLE;
              w_data_p1   = IDLE_WORD;
              w_vld_p1    = 1'b0;
              w_repeat_p1 = 1'b0;
              w_busy      = 1'b0;
            end else begin
              w_state     = (w_f_rep != '0) ? S_REP : S_RUN;
              w_rep_cnt   = w_f_rep;
              w_end       = w_f_end;
              w_data_p1   = w_f_pay;
              w_vld_p1    = 1'b1;
              w_repeat_p1 = 1'b0;
              w_upc       = w_fetch_addr;
              w_wrap      = r_wrap | (r_upc == UPC_MAX);
            end
          end
          default: w_state = S_IDLE;
        endcase
      end
    end
  end

  // Output stage: everything the datapath sees is registered here
  always_ff @(posedge i_CLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      r_state     <= S_IDLE;
      r_rep_cnt   <= '0;
      r_end       <= 1'b0;
      r_data_p1   <= IDLE_WORD;
      r_vld_p1    <= 1'b0;
      r_repeat_p1 <= 1'b0;
      r_busy      <= 1'b0;
      r_upc       <= '0;
      r_wrap      <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_rep_cnt   <= w_rep_cnt;
      r_end       <= w_end;
      r_data_p1   <= w_data_p1;
      r_vld_p1    <= w_vld_p1;
      r_repeat_p1 <= w_repeat_p1;
      r_busy      <= w_busy;
      r_upc       <= w_upc;
      r_wrap      <= w_wrap;
    end
  end

  assign bus.o_MC_DATA   = r_data_p1;
  assign bus.o_MC_VALID  = r_vld_p1;
  assign bus.o_MC_REPEAT = r_repeat_p1;
  assign bus.o_BUSY      = r_busy;
  assign bus.o_UPC       = r_upc;
  assign bus.o_WRAP      = r_wrap;
endmodule
